// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - source request/grant and CDB broadcast bundle for cdb_arbiter.
interface cdb_arbiter_if;
    logic        add_req,  mult_req,  ld_req;
    logic [3:0]  add_tag,  mult_tag,  ld_tag;
    logic [1:0]  add_rob,  mult_rob,  ld_rob;
    logic [63:0] add_data, mult_data, ld_data;
    logic        add_gnt,  mult_gnt,  ld_gnt;
    logic        cdb_valid;
    logic [3:0]  cdb_id;
    logic [1:0]  cdb_rob;
    logic [63:0] cdb_data;
    logic        proto_err;

    modport master (
        output add_req, mult_req, ld_req,
        output add_tag, mult_tag, ld_tag,
        output add_rob, mult_rob, ld_rob,
        output add_data, mult_data, ld_data,
        input  add_gnt, mult_gnt, ld_gnt,
        input  cdb_valid, cdb_id, cdb_rob, cdb_data, proto_err
    );

    modport slave (
        input  add_req, mult_req, ld_req,
        input  add_tag, mult_tag, ld_tag,
        input  add_rob, mult_rob, ld_rob,
        input  add_data, mult_data, ld_data,
        output add_gnt, mult_gnt, ld_gnt,
        output cdb_valid, cdb_id, cdb_rob, cdb_data, proto_err
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - three-source common data bus arbiter with protocol checker.
// CDB_RR_EN selects round-robin priority; undefined gives fixed add > mult > ld.
module cdb_arbiter (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);
    // Source index: 0 = add, 1 = mult, 2 = ld
    logic [2:0]  req;
    logic [2:0]  legal;
    logic [2:0]  elig;
    logic [2:0]  gnt;
    logic [3:0]  tag  [3];
    logic [1:0]  rob  [3];
    logic [63:0] data [3];

    logic        win_valid;
    logic [1:0]  win;
    logic [1:0]  ptr;
    logic        err_now;

    logic        cdb_valid;
    logic [3:0]  cdb_id;
    logic [1:0]  cdb_rob;
    logic [63:0] cdb_data;
    logic        proto_err;

    logic [2:0]  prev_req;
    logic [2:0]  prev_gnt;
    logic [3:0]  prev_tag  [3];
    logic [1:0]  prev_rob  [3];
    logic [63:0] prev_data [3];

    function automatic logic [1:0] rot(input logic [1:0] base, input int k);
        int t;
        t = int'(base) + k;
        if (t >= 3) t = t - 3;
        return t[1:0];
    endfunction

    always_comb begin
        req     = {bus.ld_req, bus.mult_req, bus.add_req};
        tag[0]  = bus.add_tag;   tag[1]  = bus.mult_tag;   tag[2]  = bus.ld_tag;
        rob[0]  = bus.add_rob;   rob[1]  = bus.mult_rob;   rob[2]  = bus.ld_rob;
        data[0] = bus.add_data;  data[1] = bus.mult_data;  data[2] = bus.ld_data;
    end

    assign legal[0] = (tag[0] >= 4'd1) && (tag[0] <= 4'd3);
    assign legal[1] = (tag[1] >= 4'd4) && (tag[1] <= 4'd5);
    assign legal[2] = (tag[2] >= 4'd6) && (tag[2] <= 4'd8);
    assign elig     = req & legal;

`ifdef CDB_RR_EN
    // Pointer moves to the source after the winner so the winner drops to lowest priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 2'd0;
        else if (win_valid)
            ptr <= rot(win, 1);
    end
`else
    assign ptr = 2'd0;
`endif

    always_comb begin
        win_valid = 1'b0;
        win       = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!win_valid && elig[rot(ptr, k)]) begin
                win_valid = 1'b1;
                win       = rot(ptr, k);
            end
        end
    end

    always_comb begin
        gnt = 3'b000;
        if (!rst && win_valid)
            gnt = 3'b001 << win;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_id    <= 4'd0;
            cdb_rob   <= 2'd0;
            cdb_data  <= 64'd0;
        end else if (win_valid) begin
            cdb_valid <= 1'b1;
            cdb_id    <= tag[win];
            cdb_rob   <= rob[win];
            cdb_data  <= data[win];
        end else begin
            cdb_valid <= 1'b0;
            cdb_id    <= 4'd0;
            cdb_rob   <= 2'd0;
            cdb_data  <= 64'd0;
        end
    end

    // An ungranted request must neither withdraw nor alter its payload
    always_comb begin
        err_now = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (req[i] && !legal[i])
                err_now = 1'b1;
            if (prev_req[i] && !prev_gnt[i]) begin
                if (!req[i])
                    err_now = 1'b1;
                else if ((tag[i] != prev_tag[i]) || (rob[i] != prev_rob[i]) ||
                         (data[i] != prev_data[i]))
                    err_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
            prev_req  <= 3'b000;
            prev_gnt  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                prev_tag[i]  <= 4'd0;
                prev_rob[i]  <= 2'd0;
                prev_data[i] <= 64'd0;
            end
        end else begin
            proto_err <= proto_err | err_now;
            prev_req  <= req;
            prev_gnt  <= gnt;
            for (int i = 0; i < 3; i++) begin
                prev_tag[i]  <= tag[i];
                prev_rob[i]  <= rob[i];
                prev_data[i] <= data[i];
            end
        end
    end

    assign bus.add_gnt   = gnt[0];
    assign bus.mult_gnt  = gnt[1];
    assign bus.ld_gnt    = gnt[2];
    assign bus.cdb_valid = cdb_valid;
    assign bus.cdb_id    = cdb_id;
    assign bus.cdb_rob   = cdb_rob;
    assign bus.cdb_data  = cdb_data;
    assign bus.proto_err = proto_err;
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 add_req / mult_req / ld_req  input  1 each  source requests a CDB broadcast; held high until granted.
REQ-004 add_tag / mult_tag / ld_tag  input  4 each  producing reservation-station tag (add 1-3, mult 4-5, ld 6-8; 0 = notag).
REQ-005 add_rob / mult_rob / ld_rob  input  2 each  ROB slot of the result.
REQ-006 add_data / mult_data / ld_data  input  64 each  result value.
REQ-007 add_gnt / mult_gnt / ld_gnt  output  1 each  combinational grant; at most one high per cycle.
REQ-008 cdb_valid  output  1  registered; broadcast present this cycle.
REQ-009 cdb_id  output  4  registered; broadcast tag, 0 when cdb_valid low.
REQ-010 cdb_rob  output  2  registered; ROB slot of broadcast.
REQ-011 cdb_data  output  64  registered; broadcast value.
REQ-012 proto_err  output  1  registered, sticky protocol-error flag.

Function
REQ-013 A source is eligible when its req is high and its tag is nonzero and inside its legal range.
REQ-014 gnt for exactly one eligible source (the arbitration winner) is asserted combinationally in the same cycle; no gnt when none eligible.
REQ-015 At the posedge after a grant, cdb_valid=1 and cdb_id/cdb_rob/cdb_data take the winner's tag/rob/data; latency req-to-broadcast is one cycle.
REQ-016 With no winner, next cycle cdb_valid=0, cdb_id=0, cdb_rob=0, cdb_data=0.
REQ-017 Each broadcast lasts exactly one cycle; back-to-back broadcasts from different sources in consecutive cycles are permitted.
REQ-018 A source seeing gnt high drops or replaces req at the next edge; a source not granted keeps req, tag, rob, data stable.
REQ-019 proto_err sets (and holds until reset) when: a req falls while its gnt was low in the previous cycle; a req is high with tag 0 or out of its range; or a source's tag/rob/data change while its req stays high and ungranted.
REQ-020 An ineligible (illegal-tag) request is never granted.
REQ-021 Per-source previous-cycle req/gnt/tag/rob/data are registered for the REQ-019 checks.

Reset
REQ-022 While rst is high: cdb_valid=0, cdb_id=0, cdb_rob=0, cdb_data=0, proto_err=0, history registers cleared, priority pointer = add.
REQ-023 rst asserted mid-broadcast clears the CDB outputs immediately (asynchronously); the pending request is not broadcast until re-granted after rst falls.
REQ-024 Grants are forced low while rst is high.

Configuration
REQ-025 Macro CDB_RR_EN defined: round-robin priority; a 2-bit pointer names the highest-priority source (add, mult, ld order), updated to the source after the winner on each grant, wrapping ld->add, unchanged when no grant.
REQ-026 CDB_RR_EN undefined: fixed priority add > mult > ld, no pointer register; all other behaviour identical.

Verification
REQ-027 Reset, then add_req=1 tag=2 rob=1 data=0x10 -> add_gnt=1 same cycle; next cycle cdb_valid=1 cdb_id=2 cdb_rob=1 cdb_data=0x10.
REQ-028 All three request simultaneously (tags 1,4,6) and stay up until granted -> RR build: broadcasts ids 1,4,6 on three consecutive cycles; fixed build: same order, and with add re-requesting every cycle mult/ld never granted.
REQ-029 RR build: pointer at mult after an add grant; add and ld request together -> ld granted first (cdb_id 7 for tag 7), then add.
REQ-030 mult_req=1 tag=2 (out of range) -> no mult_gnt, cdb_valid stays 0, proto_err=1 next cycle and remains 1.
REQ-031 ld_req high ungranted while ld_data changes 0x5->0x6 -> proto_err=1; rst pulse -> proto_err=0, cdb_valid=0.
REQ-032 Assert rst asynchronously in the cycle cdb_valid=1 -> cdb outputs 0 before next edge; no grants during rst.
